// File: rtl/scale_up_if.sv
// Pixel port bundle between the up-scaler and its surroundings.
// The scaler drives the master modport: it raises ask to pull source pixels
// and presents up-scaled pixels on out qualified by display.
interface scale_up_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in;
   logic              ask;
   logic [DATA_W-1:0] out;
   logic              display;

   modport master (
      input  in,
      output ask,
      output out,
      output display
   );

   modport slave (
      output in,
      input  ask,
      input  out,
      input  display
   );
endinterface

// File: rtl/scale_up.sv
// 2x nearest-neighbour image up-scaler.
// Loads a SRC_DIM x SRC_DIM frame into a local buffer, then streams a
// 2*SRC_DIM x 2*SRC_DIM frame in which each source pixel becomes a 2x2 block.
// Load and display alternate forever after the single IDLE cycle following reset.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle after reset release, nothing requested or shown
// LOAD  | ask=1, one source pixel written to the buffer per edge
// FETCH | one cycle bubble, first output pixel read from the buffer
// SHOW  | display=1, one up-scaled pixel per cycle in raster order
module scale_up #(
   parameter int DATA_W  = 8,
   parameter int SRC_DIM = 8
) (
   input  logic      clk,
   input  logic      reset,
   scale_up_if.master pix
);
   localparam int L    = $clog2(SRC_DIM);
   localparam int LD_W = 2 * L;
   localparam int SH_W = 2 * L + 2;
   localparam logic [LD_W-1:0] LD_LAST = LD_W'(SRC_DIM * SRC_DIM - 1);
   localparam logic [SH_W-1:0] SH_LAST = SH_W'(4 * SRC_DIM * SRC_DIM - 1);

   typedef enum logic [1:0] {IDLE, LOAD, FETCH, SHOW} state_t;

   state_t            state;
   logic [LD_W-1:0]   ld_cnt;
   logic [SH_W-1:0]   sh_cnt;
   logic [SH_W-1:0]   sh_nxt;
   logic [LD_W-1:0]   rd_addr;
   logic              ask_r;
   logic              disp_r;
   logic [DATA_W-1:0] out_r;
   logic              unused_sh_bits;

   logic [DATA_W-1:0] pix_mem [SRC_DIM*SRC_DIM];

   // The output register always holds the pixel for the current sh_cnt, so the
   // buffer is read one index ahead. Source row is the output row with its low
   // bit dropped, source column likewise: a pure bit-slice of the counter.
   assign sh_nxt         = sh_cnt + SH_W'(1);
   assign rd_addr        = {sh_nxt[SH_W-1 -: L], sh_nxt[L:1]};
   assign unused_sh_bits = ^{sh_nxt[L+1], sh_nxt[0]};

   assign pix.ask     = ask_r;
   assign pix.display = disp_r;
   assign pix.out     = out_r;

   // Frame buffer write; no reset because every entry is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         pix_mem[ld_cnt] <= pix.in;
      end
   end

   // Sequencer with registered ask/display/out; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         ld_cnt <= '0;
         sh_cnt <= '0;
         ask_r  <= 1'b0;
         disp_r <= 1'b0;
         out_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               state <= LOAD;
               ask_r <= 1'b1;
            end
            LOAD: begin
               if (ld_cnt == LD_LAST) begin
                  ld_cnt <= '0;
                  ask_r  <= 1'b0;
                  state  <= FETCH;
               end else begin
                  ld_cnt <= ld_cnt + LD_W'(1);
               end
            end
            FETCH: begin
               out_r  <= pix_mem['0];
               disp_r <= 1'b1;
               sh_cnt <= '0;
               state  <= SHOW;
            end
            SHOW: begin
               if (sh_cnt == SH_LAST) begin
                  sh_cnt <= '0;
                  disp_r <= 1'b0;
                  out_r  <= '0;
                  ask_r  <= 1'b1;
                  state  <= LOAD;
               end else begin
                  sh_cnt <= sh_nxt;
                  out_r  <= pix_mem[rd_addr];
               end
            end
            default: begin
               state  <= IDLE;
               ask_r  <= 1'b0;
               disp_r <= 1'b0;
               out_r  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_scale_up.sv
// Bench for the 2x up-scaler: a source model answers ask with patterned frames,
// pushes the expected 16x16 output into a scoreboard when a frame is complete,
// and the monitor pops and compares on every display cycle. Handshake run
// lengths and reset behaviour are checked alongside.
module tb_scale_up;
   localparam int N    = 8;
   localparam int NPIX = N * N;
   localparam int NOUT = 4 * N * N;

   logic clk;
   logic reset;

   scale_up_if #(.DATA_W(8)) u_if ();

   scale_up #(.DATA_W(8), .SRC_DIM(N)) u_dut (
      .clk   (clk),
      .reset (reset),
      .pix   (u_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk;
   int n_err;

   logic [7:0] exp_q [$];
   int         pat_q [$];
   logic [7:0] frame [NPIX];
   int         cur_pat;
   int         ld_k;
   int         shown;
   int         disp_idx;
   int         run_ask;
   int         run_disp;
   int         gap;
   logic       prev_ask;
   logic       prev_disp;
   logic       after_show;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat_val(input int pat, input int k);
      case (pat)
         0:       return 8'(k);
         1:       return 8'(255 - k);
         2:       return 8'hFF;
         default: return 8'h00;
      endcase
   endfunction

   // Expected output frame built from output coordinates by integer division.
   task automatic push_expected();
      for (int o = 0; o < NOUT; o++) begin
         int r;
         int c;
         r = o / (2 * N);
         c = o % (2 * N);
         exp_q.push_back(frame[(r / 2) * N + (c / 2)]);
      end
   endtask

   // One cycle: monitor outputs at the falling edge, then drive the next source pixel.
   task automatic tick();
      logic a;
      logic d;
      logic [7:0] e;
      @(negedge clk);
      a = u_if.ask;
      d = u_if.display;
      if (!d && prev_disp) begin
         check("disp_len", run_disp, NOUT);
         after_show = 1'b1;
         shown++;
         gap = 0;
      end
      if (!a && prev_ask) begin
         check("ask_len", run_ask, NPIX);
         gap = 0;
      end
      if (!a && !d) gap++;
      if (a && !prev_ask) begin
         if (after_show) check("ask_after_show", gap, 0);
         after_show = 1'b0;
         run_ask = 0;
      end
      if (d && !prev_disp) begin
         check("fetch_gap", gap, 1);
         run_disp = 0;
         disp_idx = 0;
      end
      if (a) run_ask++;
      if (d) begin
         run_disp++;
         if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pix", u_if.out, e);
         end
         disp_idx++;
      end else if (u_if.out !== 8'h00) begin
         check("out_idle", u_if.out, 0);
      end
      if (a && d) check("ask_disp_excl", 1, 0);
      prev_ask  = a;
      prev_disp = d;
      if (a) begin
         u_if.in = pat_val(cur_pat, ld_k);
         frame[ld_k] = u_if.in;
         ld_k++;
         if (ld_k == NPIX) begin
            push_expected();
            ld_k = 0;
            cur_pat = (pat_q.size() != 0) ? pat_q.pop_front() : 0;
         end
      end
   endtask

   // Assert reset between edges, check outputs drop at once, release on a falling edge.
   task automatic do_reset(input int next_pat);
      reset = 1'b1;
      #1;
      check("rst_ask", u_if.ask, 0);
      check("rst_display", u_if.display, 0);
      check("rst_out", u_if.out, 0);
      exp_q.delete();
      ld_k       = 0;
      cur_pat    = next_pat;
      prev_ask   = 1'b0;
      prev_disp  = 1'b0;
      after_show = 1'b0;
      gap        = 0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("idle_ask", u_if.ask, 0);
      check("idle_display", u_if.display, 0);
      tick();
      check("load_after_idle", u_if.ask, 1);
   endtask

   task automatic wait_shown(input int n);
      int cyc;
      cyc = 0;
      while (shown < n && cyc < 3000) begin
         tick();
         cyc++;
      end
      if (shown < n) check("timeout_shown", shown, n);
   endtask

   initial begin
      int cyc;
      n_chk      = 0;
      n_err      = 0;
      shown      = 0;
      disp_idx   = 0;
      run_ask    = 0;
      run_disp   = 0;
      gap        = 0;
      ld_k       = 0;
      prev_ask   = 1'b0;
      prev_disp  = 1'b0;
      after_show = 1'b0;
      reset      = 1'b0;
      u_if.in    = 8'h00;
      pat_q      = '{1, 2, 3, 0, 0};
      #2;
      // ramp, inverse ramp, all-ones, all-zeros frames back to back
      do_reset(0);
      wait_shown(4);

      // fifth frame is a ramp; reset lands during output pixel 100
      cyc = 0;
      while (!(u_if.display && disp_idx == 101) && cyc < 1000) begin
         tick();
         cyc++;
      end
      check("reach_pix100", disp_idx, 101);
      #2;
      do_reset(0);
      wait_shown(5);

      // reset after 30 source samples of the next frame, then a clean ramp frame
      cyc = 0;
      while (ld_k != 30 && cyc < 200) begin
         tick();
         cyc++;
      end
      check("reach_ld30", ld_k, 30);
      #2;
      do_reset(0);
      wait_shown(6);

      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
